// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
// State set includes FIXUP, used only when SIGNED_DIV_EN is defined.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // state | meaning
  // IDLE  | waiting for start, results held
  // RUN   | one quotient bit per cycle
  // ZERO  | divisor was zero, load fixed result
  // FIXUP | apply result signs (SIGNED_DIV_EN only)
  // DONE  | one-cycle done pulse, may accept next start
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_ZERO  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // one extra bit: the shifted remainder can exceed WIDTH bits before subtracting
  assign shifted  = {rem, bit_in};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle restoring divider with start/done handshake, one quotient bit per clock.
// Optional SIGNED_DIV_EN adds the sgn port and a FIXUP state for two's complement operands.
module div_32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SIGNED_DIV_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] RUN   = ST_RUN;
  localparam logic [2:0] ZERO  = ST_ZERO;
  localparam logic [2:0] DONE  = ST_DONE;
`ifdef SIGNED_DIV_EN
  localparam logic [2:0] FIXUP = ST_FIXUP;
`endif

  localparam logic [WIDTH-1:0] DBZ_Q = {WIDTH{DBZ_QUOTIENT[0]}};

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             q_bit;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef SIGNED_DIV_EN
  logic a_neg, b_neg, neg_q, neg_r;
  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // dividend register doubles as the quotient accumulator
  assign dvd_next = {dvd[WIDTH-2:0], q_bit};
  assign accept   = start && (state == IDLE || state == DONE);
  assign busy     = (state == RUN) || (state == ZERO)
`ifdef SIGNED_DIV_EN
                    || (state == FIXUP)
`endif
                    ;
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // divide-by-zero keeps the raw dividend so R can return it untouched
            dvd   <= (B == '0) ? A : a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            cnt   <= CNT_W'(WIDTH - 1);
            state <= (B == '0) ? ZERO : RUN;
`ifdef SIGNED_DIV_EN
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem <= rem_next;
          dvd <= dvd_next;
          if (cnt == '0) begin
`ifdef SIGNED_DIV_EN
            state <= FIXUP;
`else
            Q           <= dvd_next;
            R           <= rem_next;
            div_by_zero <= 1'b0;
            state       <= DONE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef SIGNED_DIV_EN
        FIXUP: begin
          Q           <= neg_q ? -dvd : dvd;
          R           <= neg_r ? -rem : rem;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
`endif
        ZERO: begin
          Q           <= DBZ_Q;
          R           <= dvd;
          div_by_zero <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
